// File: rtl/div_defs.sv
// Shared definitions for the iterative divider controller.
//   div_state_e      : controller state encoding (DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END)
//   DIV_CYCLES       : restoring steps per full-width divide
//   DIV_QUOT_ON_ZERO : quotient reported for a zero divisor; a signed -1 so that a size
//                      cast sign-extends it to all ones at any result width
package div_defs;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } div_state_e;

    localparam int unsigned DIV_CYCLES = 32;

    localparam int DIV_QUOT_ON_ZERO = -1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step (combinational).
// Ports:
//   rem_i  : partial remainder before the step
//   dsr_i  : divisor magnitude
//   bit_i  : next dividend bit, MSB first
//   rem_o  : partial remainder after the step
//   q_o    : quotient bit produced by the step
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dsr_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dsr_i};
    // shifted < 2*dsr always holds, so a borrow shows up as the top bit of the difference.
    assign q_o     = ~diff[WIDTH];
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle controller for the iterative DIV/DIVU divider in EX.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : EX requests a divide; signed_div selects DIV (1) or DIVU (0)
//   opdata1/opdata2 : dividend / divisor
//   flush           : annul the in-flight divide
//   stall_o         : hold IF/ID/EX while the divide is in progress
//   done            : one-cycle pulse, quot (LO) / rem (HI) valid
//   div_zero        : last completed divide had a zero divisor
// Optional build macro DIV_EARLY_EXIT_EN: |dividend| < |divisor| finishes on the short path,
// and full divides skip the dividend's leading zero bits.
module div_ctrl
    import div_defs::*;
#(
    parameter int unsigned WIDTH = DIV_CYCLES,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             flush,
    output logic             stall_o,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shifted out MSB first, quotient shifted in
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             early_q, early_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic             s1, s2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_raw;

    assign s1   = signed_div & opdata1[WIDTH-1];
    assign s2   = signed_div & opdata2[WIDTH-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign mag1 = s1 ? -opdata1 : opdata1;
    assign mag2 = s2 ? -opdata2 : opdata2;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (prem_q),
        .dsr_i (dsr_q),
        .bit_i (dvd_q[WIDTH-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign q_raw = {dvd_q[WIDTH-2:0], step_q};

`ifdef DIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] lz;

    always_comb begin
        lz = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (mag1[i]) lz = CNT_W'(int'(WIDTH) - 1 - i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        early_d = early_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        stall_o = 1'b0;
        done    = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start && !flush) begin
                    stall_o = 1'b1;
                    qneg_d  = s1 ^ s2;
                    rneg_d  = s1;
                    dsr_d   = mag2;
                    cnt_d   = '0;
                    prem_d  = '0;
                    early_d = 1'b0;
                    if (opdata2 == '0) begin
                        state_d = DIV_ZERO;
                        dvd_d   = opdata1;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (mag1 < mag2) begin
                        // ZERO doubles as the one-cycle short path, so done lands at cycle 2.
                        state_d = DIV_ZERO;
                        dvd_d   = opdata1;
                        early_d = 1'b1;
                    end else begin
                        // Leading zero dividend bits would only produce zero quotient bits.
                        state_d = DIV_ON;
                        cnt_d   = lz;
                        dvd_d   = mag1 << lz;
                    end
`else
                    else begin
                        state_d = DIV_ON;
                        dvd_d   = mag1;
                    end
`endif
                end
            end

            DIV_ZERO: begin
                stall_o = 1'b1;
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_END;
                    quot_d  = early_q ? '0 : WIDTH'(DIV_QUOT_ON_ZERO);
                    rem_d   = dvd_q;
                    dz_d    = ~early_q;
                end
            end

            DIV_ON: begin
                stall_o = 1'b1;
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    dvd_d  = q_raw;
                    prem_d = step_rem;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LastStep) begin
                        state_d = DIV_END;
                        quot_d  = qneg_q ? -q_raw : q_raw;
                        rem_d   = rneg_q ? -step_rem : step_rem;
                        dz_d    = 1'b0;
                    end
                end
            end

            DIV_END: begin
                done    = ~flush;
                state_d = DIV_IDLE;
            end

            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            early_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            early_q <= early_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = dz_q;

endmodule
